// File: rtl/lrunway_ctrl_pkg.sv
// Shared types and constants for the LRU-table sequencer/arbiter.
// Optional build macro LRUNWAY_CTRL_RR_EN selects round-robin arbitration.
package lrunway_ctrl_pkg;

    typedef enum logic [1:0] {OP_NONE, OP_VQ, OP_TOUCH, OP_INV} lru_op_t;
    typedef enum logic {ST_INIT, ST_IDLE} ctrl_state_t;

    localparam int REQ_INV   = 0;
    localparam int REQ_TOUCH = 1;
    localparam int REQ_VQ    = 2;
    localparam int NUM_REQ   = 3;

    // Keep only the lowest-numbered active request (lowest index wins).
    function automatic logic [NUM_REQ-1:0] pick_lowest(input logic [NUM_REQ-1:0] req);
        return req & (~req + 3'd1);
    endfunction

    // Round-robin pointer moves to the requester just past the winner.
    function automatic logic [1:0] rr_next(input logic [NUM_REQ-1:0] gnt);
        logic [1:0] nxt;
        nxt = 2'(REQ_INV);
        if (gnt[REQ_INV])   nxt = 2'(REQ_TOUCH);
        if (gnt[REQ_TOUCH]) nxt = 2'(REQ_VQ);
        if (gnt[REQ_VQ])    nxt = 2'(REQ_INV);
        return nxt;
    endfunction

endpackage

// File: rtl/lrunway_ctrl_if.sv
// Request/response and LRU-table pins of the sequencer, bundled as one interface.
// The slave modport is the controller side; the master modport is the environment side.
interface lrunway_ctrl_if #(
    parameter int abits   = 6,
    parameter int waybits = 2
) ();

    logic               i_flush_valid;
    logic               o_flush_ready;
    logic               i_vq_valid;
    logic [abits-1:0]   i_vq_addr;
    logic               o_vq_ready;
    logic               o_vq_resp_valid;
    logic [waybits-1:0] o_vq_resp_way;
    logic               i_touch_valid;
    logic [abits-1:0]   i_touch_addr;
    logic [waybits-1:0] i_touch_way;
    logic               o_touch_ready;
    logic               i_inv_valid;
    logic [abits-1:0]   i_inv_addr;
    logic [waybits-1:0] i_inv_way;
    logic               o_inv_ready;
    logic               o_busy;
    logic               o_tbl_init;
    logic [abits-1:0]   o_tbl_raddr;
    logic [abits-1:0]   o_tbl_waddr;
    logic               o_tbl_up;
    logic               o_tbl_down;
    logic [waybits-1:0] o_tbl_lru;
    logic [waybits-1:0] i_tbl_lru;

    modport slave (
        input  i_flush_valid, i_vq_valid, i_vq_addr,
        input  i_touch_valid, i_touch_addr, i_touch_way,
        input  i_inv_valid, i_inv_addr, i_inv_way, i_tbl_lru,
        output o_flush_ready, o_vq_ready, o_vq_resp_valid, o_vq_resp_way,
        output o_touch_ready, o_inv_ready, o_busy,
        output o_tbl_init, o_tbl_raddr, o_tbl_waddr, o_tbl_up, o_tbl_down, o_tbl_lru
    );

    modport master (
        output i_flush_valid, i_vq_valid, i_vq_addr,
        output i_touch_valid, i_touch_addr, i_touch_way,
        output i_inv_valid, i_inv_addr, i_inv_way, i_tbl_lru,
        input  o_flush_ready, o_vq_ready, o_vq_resp_valid, o_vq_resp_way,
        input  o_touch_ready, o_inv_ready, o_busy,
        input  o_tbl_init, o_tbl_raddr, o_tbl_waddr, o_tbl_up, o_tbl_down, o_tbl_lru
    );

endinterface

// File: rtl/lrunway_ctrl_arb3.sv
// Three-way grant for inv/touch/vq. Fixed priority inv > touch > vq by default;
// with LRUNWAY_CTRL_RR_EN defined, a round-robin pointer picks the starting requester.
module lru_arb3
    import lrunway_ctrl_pkg::*;
(
`ifdef LRUNWAY_CTRL_RR_EN
    input  logic               i_clk,
    input  logic               i_nrst,
`endif
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt
);

`ifdef LRUNWAY_CTRL_RR_EN
    logic [1:0]         ptr;
    logic [NUM_REQ-1:0] rot;
    logic [NUM_REQ-1:0] rot_gnt;

    // Pointer starts at inv and steps past whichever requester was just served.
    always_ff @(posedge i_clk) begin
        if (!i_nrst)
            ptr <= 2'(REQ_INV);
        else if (|gnt)
            ptr <= rr_next(gnt);
    end

    // Rotate requests so the pointed-at requester sits in bit 0, pick, then rotate back.
    always_comb begin
        rot = req;
        case (ptr)
            2'd1:    rot = {req[REQ_INV], req[REQ_VQ], req[REQ_TOUCH]};
            2'd2:    rot = {req[REQ_TOUCH], req[REQ_INV], req[REQ_VQ]};
            default: rot = req;
        endcase
        rot_gnt = en ? pick_lowest(rot) : '0;
        gnt = rot_gnt;
        case (ptr)
            2'd1:    gnt = {rot_gnt[1], rot_gnt[0], rot_gnt[2]};
            2'd2:    gnt = {rot_gnt[0], rot_gnt[2], rot_gnt[1]};
            default: gnt = rot_gnt;
        endcase
    end
`else
    // Lowest requester index always wins when arbitration is open.
    always_comb begin
        gnt = en ? pick_lowest(req) : '0;
    end
`endif

endmodule

// File: rtl/lrunway_ctrl.sv
// Sequencer/arbiter in front of a per-way LRU table: init sweep on reset/flush,
// then one granted op per cycle through a 2-stage read/write pipeline.
// Build macro LRUNWAY_CTRL_RR_EN switches inv/touch/vq arbitration to round-robin.
module lrunway_ctrl
    import lrunway_ctrl_pkg::*;
#(
    parameter int abits   = 6,
    parameter int waybits = 2
) (
    input  logic          i_clk,
    input  logic          i_nrst,
    lrunway_ctrl_if.slave bus
);

    typedef struct packed {
        ctrl_state_t        state;
        logic [abits-1:0]   cnt;
        lru_op_t            s1_op;
        logic [abits-1:0]   s1_addr;
        logic [waybits-1:0] s1_way;
    } regs_t;

    localparam regs_t RESET_REGS = '{
        state:   ST_INIT,
        cnt:     '0,
        s1_op:   OP_NONE,
        s1_addr: '0,
        s1_way:  '0
    };

    regs_t              r;
    regs_t              rin;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic               arb_en;

    // Requester vector and arbitration window: only in IDLE, out of reset, and with no flush.
    always_comb begin
        req          = '0;
        req[REQ_INV]   = bus.i_inv_valid;
        req[REQ_TOUCH] = bus.i_touch_valid;
        req[REQ_VQ]    = bus.i_vq_valid;
        arb_en = i_nrst && (r.state == ST_IDLE) && !bus.i_flush_valid;
    end

    lru_arb3 u_arb (
`ifdef LRUNWAY_CTRL_RR_EN
        .i_clk  (i_clk),
        .i_nrst (i_nrst),
`endif
        .en     (arb_en),
        .req    (req),
        .gnt    (gnt)
    );

    // State register; reset drops any in-flight stage-1 op and restarts the sweep at line 0.
    always_ff @(posedge i_clk) begin
        if (!i_nrst)
            r <= RESET_REGS;
        else
            r <= rin;
    end

    // Next-state and outputs: stage-1 completion, init sweep, stage-0 grant, reset override.
    always_comb begin
        rin       = r;
        rin.s1_op = OP_NONE;

        bus.o_flush_ready   = 1'b0;
        bus.o_inv_ready     = gnt[REQ_INV];
        bus.o_touch_ready   = gnt[REQ_TOUCH];
        bus.o_vq_ready      = gnt[REQ_VQ];
        bus.o_vq_resp_valid = 1'b0;
        bus.o_vq_resp_way   = '0;
        bus.o_busy          = 1'b0;
        bus.o_tbl_init      = 1'b0;
        bus.o_tbl_raddr     = '0;
        bus.o_tbl_waddr     = '0;
        bus.o_tbl_up        = 1'b0;
        bus.o_tbl_down      = 1'b0;
        bus.o_tbl_lru       = '0;

        case (r.s1_op)
            OP_TOUCH: begin
                bus.o_tbl_up    = 1'b1;
                bus.o_tbl_waddr = r.s1_addr;
                bus.o_tbl_lru   = r.s1_way;
            end
            OP_INV: begin
                bus.o_tbl_down  = 1'b1;
                bus.o_tbl_waddr = r.s1_addr;
                bus.o_tbl_lru   = r.s1_way;
            end
            OP_VQ: begin
                bus.o_vq_resp_valid = 1'b1;
                bus.o_vq_resp_way   = bus.i_tbl_lru;
            end
            default: ;
        endcase

        case (r.state)
            ST_INIT: begin
                bus.o_busy      = 1'b1;
                bus.o_tbl_init  = 1'b1;
                bus.o_tbl_waddr = r.cnt;
                rin.cnt         = r.cnt + abits'(1);
                if (r.cnt == '1)
                    rin.state = ST_IDLE;
            end
            ST_IDLE: begin
                if (bus.i_flush_valid) begin
                    bus.o_flush_ready = 1'b1;
                    rin.state         = ST_INIT;
                    rin.cnt           = '0;
                end else if (gnt[REQ_INV]) begin
                    bus.o_tbl_raddr = bus.i_inv_addr;
                    rin.s1_op       = OP_INV;
                    rin.s1_addr     = bus.i_inv_addr;
                    rin.s1_way      = bus.i_inv_way;
                end else if (gnt[REQ_TOUCH]) begin
                    bus.o_tbl_raddr = bus.i_touch_addr;
                    rin.s1_op       = OP_TOUCH;
                    rin.s1_addr     = bus.i_touch_addr;
                    rin.s1_way      = bus.i_touch_way;
                end else if (gnt[REQ_VQ]) begin
                    bus.o_tbl_raddr = bus.i_vq_addr;
                    rin.s1_op       = OP_VQ;
                    rin.s1_addr     = bus.i_vq_addr;
                    rin.s1_way      = '0;
                end
            end
            default: ;
        endcase

        if (!i_nrst) begin
            bus.o_flush_ready   = 1'b0;
            bus.o_vq_resp_valid = 1'b0;
            bus.o_tbl_up        = 1'b0;
            bus.o_tbl_down      = 1'b0;
            bus.o_tbl_init      = 1'b1;
            bus.o_tbl_waddr     = '0;
            bus.o_busy          = 1'b1;
        end
    end

endmodule

// File: tb/tb_lrunway_ctrl.sv
// Self-checking bench for lrunway_ctrl driving a behavioural 4-way LRU table.
// Expected grants/responses come from a queue-per-line recency model updated in grant order.
// Honours LRUNWAY_CTRL_RR_EN for the expected arbitration order.
module tb_lrunway_ctrl;
    import lrunway_ctrl_pkg::*;

    localparam int ABITS   = 6;
    localparam int WAYBITS = 2;
    localparam int LINES   = 64;

    localparam int G_NONE  = 0;
    localparam int G_FLUSH = 1;
    localparam int G_INV   = 2;
    localparam int G_TOUCH = 3;
    localparam int G_VQ    = 4;

    logic i_clk  = 1'b0;
    logic i_nrst = 1'b0;

    lrunway_ctrl_if #(.abits(ABITS), .waybits(WAYBITS)) bus ();

    lrunway_ctrl #(.abits(ABITS), .waybits(WAYBITS)) dut (
        .i_clk  (i_clk),
        .i_nrst (i_nrst),
        .bus    (bus)
    );

    always #5 i_clk = ~i_clk;

    logic       flush_p = 1'b0;
    logic       inv_p   = 1'b0;
    logic       touch_p = 1'b0;
    logic       vq_p    = 1'b0;
    logic [5:0] inv_a   = '0;
    logic [5:0] touch_a = '0;
    logic [5:0] vq_a    = '0;
    logic [1:0] inv_w   = '0;
    logic [1:0] touch_w = '0;

    assign bus.i_flush_valid = flush_p;
    assign bus.i_inv_valid   = inv_p;
    assign bus.i_inv_addr    = inv_a;
    assign bus.i_inv_way     = inv_w;
    assign bus.i_touch_valid = touch_p;
    assign bus.i_touch_addr  = touch_a;
    assign bus.i_touch_way   = touch_w;
    assign bus.i_vq_valid    = vq_p;
    assign bus.i_vq_addr     = vq_a;

    // Behavioural LRU table: packed order per line, slot 0 = LRU, slot 3 = MRU.
    logic [7:0] tbl [LINES];
    logic [5:0] rd_q;

    function automatic logic [7:0] tbl_move(input logic [7:0] ord, input logic [1:0] w, input bit up);
        logic [7:0] res;
        int n;
        res = '0;
        n = 0;
        if (!up) begin
            res[1:0] = w;
            n = 1;
        end
        for (int i = 0; i < 4; i++) begin
            if (ord[2*i +: 2] != w) begin
                res[2*n +: 2] = ord[2*i +: 2];
                n++;
            end
        end
        if (up) res[7:6] = w;
        return res;
    endfunction

    // Table write port and registered read address; reads see the latest write.
    always @(posedge i_clk) begin
        rd_q <= bus.o_tbl_raddr;
        if (bus.o_tbl_init)
            tbl[bus.o_tbl_waddr] <= 8'b11_10_01_00;
        else if (bus.o_tbl_up)
            tbl[bus.o_tbl_waddr] <= tbl_move(tbl[bus.o_tbl_waddr], bus.o_tbl_lru, 1'b1);
        else if (bus.o_tbl_down)
            tbl[bus.o_tbl_waddr] <= tbl_move(tbl[bus.o_tbl_waddr], bus.o_tbl_lru, 1'b0);
    end

    assign bus.i_tbl_lru = tbl[rd_q][1:0];

    // Reference model: per-line recency queue, front = least recently used.
    logic [1:0] mq [LINES][$];
    int         rr_ptr;
    int         sweep_left;
    int         checks;
    int         failures;
    logic       exp_rv;
    logic [1:0] exp_rw;

    function automatic void mdl_init();
        for (int l = 0; l < LINES; l++) begin
            mq[l].delete();
            for (int w = 0; w < 4; w++) mq[l].push_back(2'(w));
        end
    endfunction

    function automatic void mdl_move(input int line, input logic [1:0] w, input bit to_mru);
        for (int i = 0; i < mq[line].size(); i++) begin
            if (mq[line][i] == w) begin
                mq[line].delete(i);
                break;
            end
        end
        if (to_mru) mq[line].push_back(w);
        else        mq[line].push_front(w);
    endfunction

    function automatic int pick_grant();
        bit p [3];
        int idx;
        if (sweep_left > 0) return G_NONE;
        if (flush_p) return G_FLUSH;
        p[REQ_INV]   = inv_p;
        p[REQ_TOUCH] = touch_p;
        p[REQ_VQ]    = vq_p;
        for (int k = 0; k < 3; k++) begin
            idx = (rr_ptr + k) % 3;
            if (p[idx]) return G_INV + idx;
        end
        return G_NONE;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs mid-cycle against the model, apply the expected grant, advance.
    task automatic run_cycle();
        int         g;
        logic       rv_next;
        logic [1:0] rw_next;
        @(negedge i_clk);
        checkOutput("resp_valid", 32'(bus.o_vq_resp_valid), 32'(exp_rv));
        if (exp_rv) checkOutput("resp_way", 32'(bus.o_vq_resp_way), 32'(exp_rw));
        checkOutput("busy", 32'(bus.o_busy), 32'(sweep_left > 0));
        if (sweep_left > 0) begin
            checkOutput("init", 32'(bus.o_tbl_init), 32'd1);
            checkOutput("init_waddr", 32'(bus.o_tbl_waddr), 32'(LINES - sweep_left));
        end
        g = pick_grant();
        checkOutput("ready", 32'({bus.o_flush_ready, bus.o_inv_ready, bus.o_touch_ready, bus.o_vq_ready}),
                    32'({g == G_FLUSH, g == G_INV, g == G_TOUCH, g == G_VQ}));
        rv_next = 1'b0;
        rw_next = '0;
        if (sweep_left > 0) sweep_left--;
        case (g)
            G_FLUSH: begin
                mdl_init();
                sweep_left = LINES;
            end
            G_INV:   mdl_move(int'(inv_a), inv_w, 1'b0);
            G_TOUCH: mdl_move(int'(touch_a), touch_w, 1'b1);
            G_VQ: begin
                rv_next = 1'b1;
                rw_next = mq[vq_a][0];
            end
            default: ;
        endcase
`ifdef LRUNWAY_CTRL_RR_EN
        if (g >= G_INV) rr_ptr = (g - G_INV + 1) % 3;
`endif
        @(posedge i_clk);
        #1;
        exp_rv = rv_next;
        exp_rw = rw_next;
        case (g)
            G_FLUSH: flush_p = 1'b0;
            G_INV:   inv_p   = 1'b0;
            G_TOUCH: touch_p = 1'b0;
            G_VQ:    vq_p    = 1'b0;
            default: ;
        endcase
    endtask

    // Hold reset for some cycles, checking the forced reset outputs, then release.
    task automatic do_reset(input int hold);
        i_nrst = 1'b0;
        repeat (hold) begin
            @(negedge i_clk);
            checkOutput("rst_busy", 32'(bus.o_busy), 32'd1);
            checkOutput("rst_init", 32'(bus.o_tbl_init), 32'd1);
            checkOutput("rst_waddr", 32'(bus.o_tbl_waddr), 32'd0);
            checkOutput("rst_ready", 32'({bus.o_flush_ready, bus.o_inv_ready, bus.o_touch_ready, bus.o_vq_ready}), 32'd0);
            checkOutput("rst_resp", 32'(bus.o_vq_resp_valid), 32'd0);
            checkOutput("rst_updown", 32'({bus.o_tbl_up, bus.o_tbl_down}), 32'd0);
            @(posedge i_clk);
            #1;
        end
        i_nrst     = 1'b1;
        exp_rv     = 1'b0;
        sweep_left = LINES;
        rr_ptr     = REQ_INV;
        mdl_init();
    endtask

    task automatic applyStimulus();
        if (!inv_p && $urandom_range(0, 2) == 0) begin
            inv_p = 1'b1;
            inv_a = 6'($urandom_range(0, 3));
            inv_w = 2'($urandom_range(0, 3));
        end
        if (!touch_p && $urandom_range(0, 1) == 0) begin
            touch_p = 1'b1;
            touch_a = 6'($urandom_range(0, 3));
            touch_w = 2'($urandom_range(0, 3));
        end
        if (!vq_p && $urandom_range(0, 1) == 0) begin
            vq_p = 1'b1;
            vq_a = 6'($urandom_range(0, 3));
        end
        if (!flush_p && sweep_left == 0 && $urandom_range(0, 149) == 0)
            flush_p = 1'b1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        exp_rv   = 1'b0;
        exp_rw   = '0;
        rr_ptr   = REQ_INV;
        sweep_left = 0;

        $display("[TB] reset and initial sweep");
        vq_p = 1'b1;
        vq_a = 6'd7;
        do_reset(3);
        repeat (LINES + 2) run_cycle();

        $display("[TB] touch then victim query, back-to-back on one line");
        touch_p = 1'b1; touch_a = 6'd5; touch_w = 2'd0;
        vq_p    = 1'b1; vq_a    = 6'd5;
        repeat (3) run_cycle();

        $display("[TB] touch all ways, invalidate one way");
        for (int w = 0; w < 4; w++) begin
            touch_p = 1'b1; touch_a = 6'd9; touch_w = 2'(w);
            run_cycle();
        end
        vq_p = 1'b1; vq_a = 6'd9;
        run_cycle();
        inv_p = 1'b1; inv_a = 6'd9; inv_w = 2'd2;
        run_cycle();
        vq_p = 1'b1; vq_a = 6'd9;
        repeat (2) run_cycle();

        $display("[TB] simultaneous inv and touch");
        for (int i = 0; i < 4; i++) begin
            inv_p   = 1'b1; inv_a   = 6'd12; inv_w   = 2'd1;
            touch_p = 1'b1; touch_a = 6'd12; touch_w = 2'd3;
            run_cycle();
        end
        repeat (2) run_cycle();

        $display("[TB] flush with victim query in flight");
        vq_p = 1'b1; vq_a = 6'd9;
        run_cycle();
        flush_p = 1'b1;
        run_cycle();
        repeat (LINES) run_cycle();
        vq_p = 1'b1; vq_a = 6'd33;
        repeat (2) run_cycle();

        $display("[TB] reset mid-sweep and with a query in flight");
        do_reset(1);
        repeat (30) run_cycle();
        do_reset(1);
        repeat (LINES) run_cycle();
        vq_p = 1'b1; vq_a = 6'd9;
        run_cycle();
        do_reset(1);
        repeat (LINES + 1) run_cycle();

        $display("[TB] randomized traffic");
        repeat (600) begin
            applyStimulus();
            run_cycle();
        end
        repeat (4) run_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
